sort_loader: RTL

SORT_LOADER -- requirements
Module: sort_loader

---
 rtl/sort_loader.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/sort_loader.sv
// -----------------------------------------------------------------------------
// sort_loader
//
// Streams N words from an upstream valid/ready source into a sort memory at
// addresses 0..N-1. It then kicks an external sort controller and waits for
// that controller to report completion before signalling job done.
//
// Ports
//   i_clk         single clock, all state changes on the rising edge
//   i_rst         synchronous active-high reset
//   i_start       begin a load-and-sort job (only honoured in Idle)
//   i_in_valid    upstream word present on i_in_data
//   i_in_data     upstream data word (W bits)
//   o_in_ready    loader accepts i_in_data this cycle (Load state only)
//   o_mem_addr    sort memory write address, always the word counter
//   o_mem_wdata   sort memory write data, always i_in_data
//   o_mem_wr      sort memory write strobe, the only write qualifier
//   o_sort_start  one-cycle start pulse to the sort controller
//   i_sort_done   done pulse from the sort controller (honoured in Wait only)
//   o_busy        high in every state except Idle
//   o_done        one-cycle pulse when the sorted job is complete
// -----------------------------------------------------------------------------
module sort_loader #(
   parameter int N  = 8,
   parameter int W  = 8,
   parameter int AW = 3
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_start,
   input  logic          i_in_valid,
   input  logic [W-1:0]  i_in_data,
   output logic          o_in_ready,
   output logic [AW-1:0] o_mem_addr,
   output logic [W-1:0]  o_mem_wdata,
   output logic          o_mem_wr,
   output logic          o_sort_start,
   input  logic          i_sort_done,
   output logic          o_busy,
   output logic          o_done
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_INIT = 3'd1,
      S_LOAD = 3'd2,
      S_KICK = 3'd3,
      S_WAIT = 3'd4,
      S_DONE = 3'd5
   } state_t;

   // Counter value of the final word of a job.
   localparam logic [AW-1:0] LAST_CNT = AW'(N - 1);

   state_t          r_state;
   state_t          w_next_state;
   logic [AW-1:0]   r_cnt;
   logic            r_in_ready;
   logic            r_busy;
   logic            r_sort_start;
   logic            r_done;
   logic            w_xfer;

   // A transfer is a Load cycle with a valid word. Reset blocks it so that an
   // aborted job cannot disturb memory in the cycle reset is applied.
   assign w_xfer = r_in_ready & i_in_valid & ~i_rst;

   // Next-state decode for the job sequence.
   always_comb begin
      w_next_state = S_IDLE;
      case (r_state)
         S_IDLE: begin
            if (i_start) begin
               w_next_state = S_INIT;
            end else begin
               w_next_state = S_IDLE;
            end
         end
         S_INIT: begin
            w_next_state = S_LOAD;
         end
         S_LOAD: begin
            if (w_xfer && (r_cnt == LAST_CNT)) begin
               w_next_state = S_KICK;
            end else begin
               w_next_state = S_LOAD;
            end
         end
         S_KICK: begin
            // i_sort_done here is deliberately not looked at.
            w_next_state = S_WAIT;
         end
         S_WAIT: begin
            if (i_sort_done) begin
               w_next_state = S_DONE;
            end else begin
               w_next_state = S_WAIT;
            end
         end
         S_DONE: begin
            w_next_state = S_IDLE;
         end
         default: begin
            // Unused encodings recover to Idle.
            w_next_state = S_IDLE;
         end
      endcase
   end

   // State register, word counter and Moore output flags. The flags are
   // decoded from the next state so they line up with the present state
   // one edge later, which keeps them glitch-free.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state      <= S_IDLE;
         r_cnt        <= '0;
         r_in_ready   <= 1'b0;
         r_busy       <= 1'b0;
         r_sort_start <= 1'b0;
         r_done       <= 1'b0;
      end else begin
         r_state      <= w_next_state;
         r_in_ready   <= (w_next_state == S_LOAD);
         r_busy       <= (w_next_state != S_IDLE);
         r_sort_start <= (w_next_state == S_KICK);
         r_done       <= (w_next_state == S_DONE);
         if (r_state == S_INIT) begin
            r_cnt <= '0;
         end else if (w_xfer) begin
            // Wraps harmlessly after the last word; Init clears it per job.
            r_cnt <= r_cnt + AW'(1);
         end else begin
            r_cnt <= r_cnt;
         end
      end
   end

   // Reset forces every control output low even in the cycle it is first
   // applied, before the state register has returned to Idle.
   assign o_in_ready   = r_in_ready & ~i_rst;
   assign o_mem_wr     = w_xfer;
   assign o_sort_start = r_sort_start & ~i_rst;
   assign o_busy       = r_busy & ~i_rst;
   assign o_done       = r_done & ~i_rst;

   // Address and data are unqualified; o_mem_wr alone decides a write.
   assign o_mem_addr   = r_cnt;
   assign o_mem_wdata  = i_in_data;

endmodule
